// File: rtl/pmic_poll_sequencer_if.sv
// Transaction bus between the PMIC poll sequencer (master) and the I2C handler (slave).
interface pmic_poll_sequencer_if;
    logic        o_begin;
    logic        o_writeEnable;
    logic [6:0]  o_i2cAddress;
    logic [7:0]  o_regAddress;
    logic [15:0] o_txData;
    logic [1:0]  o_bytesToTx;
    logic [1:0]  o_bytesToRx;
    logic [15:0] i_rxData;
    logic        i_done;

    modport master (
        output o_begin, o_writeEnable, o_i2cAddress, o_regAddress,
               o_txData, o_bytesToTx, o_bytesToRx,
        input  i_rxData, i_done
    );

    modport slave (
        input  o_begin, o_writeEnable, o_i2cAddress, o_regAddress,
               o_txData, o_bytesToTx, o_bytesToRx,
        output i_rxData, i_done
    );
endinterface

// File: rtl/pmic_poll_sequencer.sv
// Brings up a PMIC with two register writes, then polls one 16-bit register periodically,
// retrying timed-out transactions and latching a sticky fault after too many.
module pmic_poll_sequencer #(
    parameter logic [6:0]  I2C_ADDR      = 7'h48,
    parameter logic [7:0]  INIT_REG0     = 8'h01,
    parameter logic [15:0] INIT_DATA0    = 16'h0000,
    parameter logic [7:0]  INIT_REG1     = 8'h02,
    parameter logic [15:0] INIT_DATA1    = 16'h0000,
    parameter logic [7:0]  POLL_REG      = 8'h00,
    parameter logic [23:0] POLL_PERIOD   = 24'd100000,
    parameter logic [23:0] TIMEOUT       = 24'd50000,
    parameter logic [1:0]  MAX_RETRIES   = 2'd3,
    parameter logic [7:0]  STARTUP_DELAY = 8'd64
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    pmic_poll_sequencer_if.master hif,
    output logic [15:0]           o_value,
    output logic                  o_valid,
    output logic                  o_initDone,
    output logic                  o_fault
);

    typedef enum logic [3:0] {
        WAIT_START, INIT0, INIT0_WAIT, INIT1, INIT1_WAIT,
        POLL_IDLE, POLL_REQ, POLL_WAIT, FAULT
    } state_t;

    typedef struct packed {
        logic        we;
        logic [6:0]  addr;
        logic [7:0]  regA;
        logic [15:0] tx;
        logic [1:0]  ntx;
        logic [1:0]  nrx;
    } desc_t;

    // The i_done cycle counts as the first period cycle, so the next request
    // lands exactly POLL_PERIOD cycles after it.
    localparam logic [23:0] PERIOD_LOAD = (POLL_PERIOD == 24'd0) ? 24'd0 : POLL_PERIOD - 24'd1;

    state_t      state_q;
    desc_t       desc_q;
    logic        begin_q;
    logic        valid_q;
    logic        init_done_q;
    logic        fault_q;
    logic [15:0] value_q;
    logic [7:0]  start_cnt_q;
    logic [23:0] tcnt_q;
    logic [23:0] pcnt_q;
    logic [1:0]  retry_q;

    logic [23:0] tcnt_d;
    logic [23:0] pcnt_d;
    logic        retry_exhausted_d;
    logic        start_done_d;

    always_comb begin
        tcnt_d            = (tcnt_q == '0) ? '0 : tcnt_q - 24'd1;
        pcnt_d            = (pcnt_q == '0) ? '0 : pcnt_q - 24'd1;
        retry_exhausted_d = ({1'b0, retry_q} + 3'd1) >= {1'b0, MAX_RETRIES};
        start_done_d      = ({1'b0, start_cnt_q} + 9'd1) >= {1'b0, STARTUP_DELAY};
    end

    function automatic desc_t desc_for(input state_t s);
        desc_t d;
        d = '0;
        case (s)
            INIT0: begin
                d.we   = 1'b1;
                d.addr = I2C_ADDR;
                d.regA = INIT_REG0;
                d.tx   = {8'h00, INIT_DATA0[7:0]};
                d.ntx  = 2'd1;
            end
            INIT1: begin
                d.we   = 1'b1;
                d.addr = I2C_ADDR;
                d.regA = INIT_REG1;
                d.tx   = INIT_DATA1;
                d.ntx  = 2'd2;
            end
            POLL_REQ: begin
                d.addr = I2C_ADDR;
                d.regA = POLL_REG;
                d.nrx  = 2'd2;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

    function automatic state_t req_of(input state_t s);
        case (s)
            INIT0_WAIT: return INIT0;
            INIT1_WAIT: return INIT1;
            default:    return POLL_REQ;
        endcase
    endfunction

    // Request states are entered with o_begin, descriptor and timeout already
    // registered, so the request cycle itself counts toward the timeout.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= WAIT_START;
            desc_q      <= '0;
            begin_q     <= 1'b0;
            valid_q     <= 1'b0;
            init_done_q <= 1'b0;
            fault_q     <= 1'b0;
            value_q     <= '0;
            start_cnt_q <= '0;
            tcnt_q      <= '0;
            pcnt_q      <= '0;
            retry_q     <= '0;
        end else begin
            begin_q <= 1'b0;
            valid_q <= 1'b0;
            case (state_q)
                WAIT_START: begin
                    if (start_done_d) begin
                        start_cnt_q <= '0;
                        state_q     <= INIT0;
                        begin_q     <= 1'b1;
                        desc_q      <= desc_for(INIT0);
                        tcnt_q      <= TIMEOUT;
                    end else begin
                        start_cnt_q <= start_cnt_q + 8'd1;
                    end
                end
                INIT0: begin
                    state_q <= INIT0_WAIT;
                    tcnt_q  <= tcnt_d;
                end
                INIT1: begin
                    state_q <= INIT1_WAIT;
                    tcnt_q  <= tcnt_d;
                end
                POLL_REQ: begin
                    state_q <= POLL_WAIT;
                    tcnt_q  <= tcnt_d;
                end
                INIT0_WAIT, INIT1_WAIT, POLL_WAIT: begin
                    if (hif.i_done) begin
                        retry_q <= '0;
                        tcnt_q  <= '0;
                        case (state_q)
                            INIT0_WAIT: begin
                                state_q <= INIT1;
                                begin_q <= 1'b1;
                                desc_q  <= desc_for(INIT1);
                                tcnt_q  <= TIMEOUT;
                            end
                            INIT1_WAIT: begin
                                state_q     <= POLL_IDLE;
                                init_done_q <= 1'b1;
                                pcnt_q      <= PERIOD_LOAD;
                            end
                            default: begin
                                state_q <= POLL_IDLE;
                                value_q <= hif.i_rxData;
                                valid_q <= 1'b1;
                                pcnt_q  <= PERIOD_LOAD;
                            end
                        endcase
                    end else if (tcnt_q <= 24'd1) begin
                        if (retry_exhausted_d) begin
                            state_q <= FAULT;
                            fault_q <= 1'b1;
                            tcnt_q  <= '0;
                        end else begin
                            retry_q <= retry_q + 2'd1;
                            state_q <= req_of(state_q);
                            begin_q <= 1'b1;
                            desc_q  <= desc_for(req_of(state_q));
                            tcnt_q  <= TIMEOUT;
                        end
                    end else begin
                        tcnt_q <= tcnt_d;
                    end
                end
                POLL_IDLE: begin
                    if (pcnt_q <= 24'd1 && i_enable) begin
                        pcnt_q  <= '0;
                        state_q <= POLL_REQ;
                        begin_q <= 1'b1;
                        desc_q  <= desc_for(POLL_REQ);
                        tcnt_q  <= TIMEOUT;
                    end else begin
                        pcnt_q <= pcnt_d;
                    end
                end
                FAULT: state_q <= FAULT;
                default: state_q <= WAIT_START;
            endcase
        end
    end

    assign hif.o_begin       = begin_q;
    assign hif.o_writeEnable = desc_q.we;
    assign hif.o_i2cAddress  = desc_q.addr;
    assign hif.o_regAddress  = desc_q.regA;
    assign hif.o_txData      = desc_q.tx;
    assign hif.o_bytesToTx   = desc_q.ntx;
    assign hif.o_bytesToRx   = desc_q.nrx;
    assign o_value           = value_q;
    assign o_valid           = valid_q;
    assign o_initDone        = init_done_q;
    assign o_fault           = fault_q;

endmodule

// File: tb/tb_pmic_poll_sequencer.sv
// Self-checking bench for pmic_poll_sequencer: handler model, descriptor/value scoreboards,
// table-driven poll vectors and hand-written retry, fault and reset sequences.
module tb_pmic_poll_sequencer;

    localparam logic [6:0] ADDR = 7'h5A;
    localparam logic [35:0] D_INIT0 = {1'b1, ADDR, 8'h11, 16'h00A5, 2'd1, 2'd0};
    localparam logic [35:0] D_INIT1 = {1'b1, ADDR, 8'h22, 16'hC3D4, 2'd2, 2'd0};
    localparam logic [35:0] D_POLL  = {1'b0, ADDR, 8'h33, 16'h0000, 2'd0, 2'd2};

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [15:0] value;
    logic        valid;
    logic        init_done;
    logic        fault;

    pmic_poll_sequencer_if hif ();

    pmic_poll_sequencer #(
        .I2C_ADDR      (ADDR),
        .INIT_REG0     (8'h11),
        .INIT_DATA0    (16'h00A5),
        .INIT_REG1     (8'h22),
        .INIT_DATA1    (16'hC3D4),
        .POLL_REG      (8'h33),
        .POLL_PERIOD   (24'd100),
        .TIMEOUT       (24'd50),
        .MAX_RETRIES   (2'd3),
        .STARTUP_DELAY (8'd64)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_enable   (enable),
        .hif        (hif),
        .o_value    (value),
        .o_valid    (valid),
        .o_initDone (init_done),
        .o_fault    (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    logic [35:0] exp_desc_q[$];
    logic [15:0] exp_val_q[$];
    int          begin_times[$];

    typedef struct {
        logic [15:0] rx;
        int unsigned dly;
        logic [15:0] exp_value;
        int          exp_gap;
    } vec_t;
    vec_t vecs[5];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [35:0] cur_desc();
        return {hif.o_writeEnable, hif.o_i2cAddress, hif.o_regAddress,
                hif.o_txData, hif.o_bytesToTx, hif.o_bytesToRx};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every o_begin pops an expected descriptor, every o_valid an expected value.
    always @(negedge clk) begin
        if (hif.o_begin === 1'b1) begin
            begin_times.push_back(cyc);
            if (exp_desc_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_begin: got o_begin desc 0x%0h, expected no request (cycle %0d)",
                         cur_desc(), cyc);
            end else begin
                chk("begin_desc", cur_desc(), exp_desc_q.pop_front());
            end
        end
        if (valid === 1'b1) begin
            if (exp_val_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_valid: got o_valid with o_value 0x%0h, expected no pulse (cycle %0d)",
                         value, cyc);
            end else begin
                chk("valid_value", value, exp_val_q.pop_front());
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_begin(input string name, output int at);
        int n;
        n = 0;
        while (begin_times.size() == 0 && n < 400) begin
            step();
            n++;
        end
        tests++;
        if (begin_times.size() == 0) begin
            failed++;
            $display("FAIL %s_timeout: got no o_begin in %0d cycles, expected a request", name, n);
            at = cyc;
        end else begin
            at = begin_times.pop_front();
        end
    endtask

    task automatic respond(input int unsigned dly, input bit rd, input logic [15:0] rx,
                           input logic [15:0] expv, input logic [35:0] expd, output int d);
        repeat (dly) step();
        chk("desc_hold", cur_desc(), expd);
        hif.i_rxData = rx;
        hif.i_done   = 1'b1;
        d = cyc;
        if (rd) exp_val_q.push_back(expv);
        step();
        hif.i_done   = 1'b0;
        hif.i_rxData = '0;
        chk("valid_pulse", valid, rd);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_begin"}, hif.o_begin, 0);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_initdone"}, init_done, 0);
        chk({tag, "_fault"}, fault, 0);
        chk({tag, "_value"}, value, 0);
        chk({tag, "_desc"}, cur_desc(), 0);
    endtask

    initial begin
        int rel, at, d, e, a1, a2, b1, b2, b3, f1, f2, f3;
        vecs[0] = '{16'hBEEF, 20, 16'hBEEF, 100};
        vecs[1] = '{16'h0000,  1, 16'h0000, 100};
        vecs[2] = '{16'hFFFF, 49, 16'hFFFF, 100};
        vecs[3] = '{16'h1234,  7, 16'h1234, 100};
        vecs[4] = '{16'h8001, 33, 16'h8001, 100};

        hif.i_done   = 1'b0;
        hif.i_rxData = '0;
        enable       = 1'b1;
        rst_n        = 1'b0;
        repeat (3) step();
        check_reset("por");

        // Bring-up: startup delay, INIT0 then INIT1, init-done flag.
        rst_n = 1'b1;
        rel   = cyc;
        exp_desc_q.push_back(D_INIT0);
        wait_begin("init0", at);
        chk("startup_latency", at - rel, 64);
        exp_desc_q.push_back(D_INIT1);
        respond(20, 1'b0, 16'h0000, 16'h0000, D_INIT0, d);
        wait_begin("init1", at);
        chk("init1_gap", at - d, 1);
        chk("initdone_before", init_done, 0);
        respond(20, 1'b0, 16'h0000, 16'h0000, D_INIT1, d);
        chk("initdone_after", init_done, 1);

        for (int i = 0; i < 5; i++) begin
            exp_desc_q.push_back(D_POLL);
            wait_begin("poll", at);
            chk("poll_gap", at - d, vecs[i].exp_gap);
            respond(vecs[i].dly, 1'b1, vecs[i].rx, vecs[i].exp_value, D_POLL, d);
            chk("poll_value", value, vecs[i].exp_value);
        end
        chk("fault_clear", fault, 0);

        // Period expires with polling disabled; a stray i_done in POLL_IDLE is ignored.
        enable = 1'b0;
        for (int i = 0; i < 500; i++) begin
            step();
            if (i == 40) begin
                hif.i_rxData = 16'hDEAD;
                hif.i_done   = 1'b1;
            end else begin
                hif.i_done   = 1'b0;
                hif.i_rxData = '0;
            end
        end
        chk("disabled_no_begin", begin_times.size(), 0);
        chk("idle_done_ignored", value, vecs[4].exp_value);
        exp_desc_q.push_back(D_POLL);
        enable = 1'b1;
        e = cyc;
        wait_begin("enable_poll", at);
        chk("enable_latency", at - e, 1);

        // Reset in POLL_WAIT abandons the read; i_done during/after reset is ignored.
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        check_reset("mid_reset");
        step();
        hif.i_rxData = 16'hCAFE;
        hif.i_done   = 1'b1;
        step();
        hif.i_done = 1'b0;
        rst_n      = 1'b1;
        rel        = cyc;
        repeat (10) step();
        hif.i_done = 1'b1;
        step();
        hif.i_done   = 1'b0;
        hif.i_rxData = '0;
        chk("restart_value", value, 0);
        chk("restart_initdone", init_done, 0);

        // One dropped INIT0, two dropped INIT1: retries clear on success, no fault.
        exp_desc_q.push_back(D_INIT0);
        exp_desc_q.push_back(D_INIT0);
        wait_begin("restart_init0", a1);
        chk("restart_latency", a1 - rel, 64);
        wait_begin("retry_init0", a2);
        chk("retry_gap", a2 - a1, 50);
        repeat (3) exp_desc_q.push_back(D_INIT1);
        respond(5, 1'b0, 16'h0000, 16'h0000, D_INIT0, d);
        wait_begin("retry_init1_a", b1);
        chk("retry_init1_gap_a", b1 - d, 1);
        wait_begin("retry_init1_b", b2);
        chk("retry_init1_gap_b", b2 - b1, 50);
        wait_begin("retry_init1_c", b3);
        chk("retry_init1_gap_c", b3 - b2, 50);
        respond(10, 1'b0, 16'h0000, 16'h0000, D_INIT1, d);
        chk("retry_initdone", init_done, 1);
        chk("retry_no_fault", fault, 0);

        // Handler never answers: three INIT0 attempts, then a sticky terminal fault.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        rel   = cyc;
        repeat (3) exp_desc_q.push_back(D_INIT0);
        wait_begin("fault_init0_a", f1);
        chk("fault_latency", f1 - rel, 64);
        wait_begin("fault_init0_b", f2);
        chk("fault_gap_b", f2 - f1, 50);
        wait_begin("fault_init0_c", f3);
        chk("fault_gap_c", f3 - f2, 50);
        repeat (49) step();
        chk("fault_before_expiry", fault, 0);
        step();
        chk("fault_set", fault, 1);
        repeat (300) step();
        chk("fault_no_begin", begin_times.size(), 0);
        chk("fault_sticky", fault, 1);
        chk("fault_initdone", init_done, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/pmic_poll_sequencer.md
PMIC_POLL_SEQUENCER -- requirements
Module: pmic_poll_sequencer

Interface
REQ-001 SHALL have parameter I2C_ADDR, 7'h48, 7-bit PMIC slave address.
REQ-002 SHALL have parameters INIT_REG0, 8'h01 and INIT_DATA0, 16'h0000: first init write, register and 1-byte data in [7:0].
REQ-003 SHALL have parameters INIT_REG1, 8'h02 and INIT_DATA1, 16'h0000: second init write, register and 2-byte data.
REQ-004 SHALL have parameter POLL_REG, 8'h00, the 2-byte register read periodically.
REQ-005 SHALL have parameter POLL_PERIOD, 24'd100000, cycles from the end of one poll to the next poll request.
REQ-006 SHALL have parameter TIMEOUT, 24'd50000, maximum cycles from o_begin to i_done.
REQ-007 SHALL have parameter MAX_RETRIES, 2'd3, timeouts tolerated per transaction before fault.
REQ-008 SHALL have parameter STARTUP_DELAY, 8'd64, idle cycles after reset release before the first transaction.
REQ-009 i_clk  in  1  system clock; all logic on its rising edge.
REQ-010 i_rst_n  in  1  asynchronous active-low reset.
REQ-011 i_enable  in  1  high permits periodic polling; init runs regardless.
REQ-012 o_begin  out  1  one-cycle start pulse to the I2C handler.
REQ-013 o_writeEnable, o_i2cAddress[6:0], o_regAddress[7:0], o_txData[15:0], o_bytesToTx[1:0], o_bytesToRx[1:0]  out  transaction descriptor to the handler.
REQ-014 i_rxData  in  16  read data from the handler.
REQ-015 i_done  in  1  one-cycle transaction-complete pulse from the handler.
REQ-016 o_value  out  16  last polled register value; o_valid  out  1  one-cycle pulse when o_value updates.
REQ-017 o_initDone  out  1  high once both init writes have completed.
REQ-018 o_fault  out  1  sticky; high after MAX_RETRIES consecutive timeouts.

Function
REQ-019 SHALL implement states WAIT_START, INIT0, INIT0_WAIT, INIT1, INIT1_WAIT, POLL_IDLE, POLL_REQ, POLL_WAIT, FAULT.
REQ-020 SHALL remain in WAIT_START for exactly STARTUP_DELAY cycles after reset release, then go to INIT0.
REQ-021 In INIT0/INIT1/POLL_REQ, SHALL drive the descriptor, assert o_begin for exactly one cycle, load the timeout counter with TIMEOUT and enter the matching wait state.
REQ-022 The descriptor SHALL hold stable from the o_begin cycle until i_done or timeout.
REQ-023 INIT0 SHALL drive: write, address I2C_ADDR, reg INIT_REG0, data INIT_DATA0, bytesToTx 1, bytesToRx 0.
REQ-024 INIT1 SHALL drive: write, address I2C_ADDR, reg INIT_REG1, data INIT_DATA1, bytesToTx 2, bytesToRx 0.
REQ-025 POLL_REQ SHALL drive: read, address I2C_ADDR, reg POLL_REG, txData 0, bytesToTx 0, bytesToRx 2.
REQ-026 In a wait state, i_done SHALL clear the retry count and advance: INIT0_WAIT->INIT1, INIT1_WAIT->POLL_IDLE with o_initDone set, POLL_WAIT->POLL_IDLE.
REQ-027 On i_done in POLL_WAIT, SHALL latch i_rxData into o_value and pulse o_valid on the next cycle.
REQ-028 i_done SHALL be ignored outside the wait states.
REQ-029 In a wait state, the timeout counter SHALL decrement each cycle; on reaching 0 without i_done, the retry count SHALL increment and the state SHALL return to the same request state.
REQ-030 If the retry count would reach MAX_RETRIES, SHALL instead enter FAULT and set o_fault.
REQ-031 i_done arriving in the same cycle as timeout expiry SHALL count as success.
REQ-032 POLL_IDLE SHALL load a 24-bit period counter with POLL_PERIOD on entry and enter POLL_REQ when it reaches 0 and i_enable is high.
REQ-033 If i_enable is low when the period counter reaches 0, SHALL hold in POLL_IDLE with the counter at 0 and request on the first cycle i_enable is high.
REQ-034 FAULT SHALL be terminal, with no further o_begin until reset.
REQ-035 Counters SHALL saturate at 0 and never wrap.

Reset
REQ-036 On i_rst_n low, asynchronously: state WAIT_START; o_begin, o_valid, o_initDone, o_fault 0; o_value 0; descriptor outputs 0; all counters 0.
REQ-037 Reset mid-transaction SHALL abandon it; a later i_done is ignored until the next wait state.

Verification
REQ-038 Release reset, handler model with i_done 20 cycles after each o_begin -> first o_begin STARTUP_DELAY cycles after release, INIT0 then INIT1 descriptors, o_initDone high after the second i_done.
REQ-039 POLL_PERIOD=100, i_enable=1, model returns 16'hBEEF -> o_value=16'hBEEF with o_valid pulse; next o_begin 100 cycles after that i_done.
REQ-040 TIMEOUT=50, model drops the first INIT0 begin -> second INIT0 o_begin 50 cycles after the first; o_fault stays 0.
REQ-041 Model never responds, MAX_RETRIES=3 -> three INIT0 o_begin pulses, then o_fault=1 and no further o_begin.
REQ-042 i_enable=0 across period expiry for 500 cycles, then 1 -> no o_begin while low; o_begin on the cycle after i_enable rises.
REQ-043 Assert i_rst_n low during POLL_WAIT, then pulse i_done -> outputs at reset values; i_done ignored; sequence restarts from WAIT_START.
